// File: rtl/fde_pkg.sv
// Shared types and constants for the fetch/decode/execute phase machine.
package fde_pkg;

   // Phase encoding; FDE_ILLEGAL is the unused code that the FSM recovers from.
   typedef enum logic [1:0] {
      FDE_FETCH   = 2'b00,
      FDE_DECODE  = 2'b01,
      FDE_EXECUTE = 2'b10,
      FDE_ILLEGAL = 2'b11
   } fde_phase_e;

   localparam int FDE_COUNT_W = 16;

endpackage

// File: rtl/fde_if.sv
// Bundle of the phase machine's enable and status signals.
interface fde_if #(
   parameter int COUNT_W = fde_pkg::FDE_COUNT_W
);
   logic               en;
   logic               fetch;
   logic               decode;
   logic               execute;
   logic [1:0]         state;
   logic               instr_done;
   logic [COUNT_W-1:0] instr_count;

   modport master (
      output en,
      input  fetch, decode, execute, state, instr_done, instr_count
   );

   modport slave (
      input  en,
      output fetch, decode, execute, state, instr_done, instr_count
   );
endinterface

// File: rtl/fde_counter.sv
// Wrapping retired-instruction counter with synchronous clear.
module fde_counter #(
   parameter int COUNT_W = fde_pkg::FDE_COUNT_W
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               inc,
   output logic [COUNT_W-1:0] count
);

   // Clear wins over increment; all-ones rolls over to zero silently.
   always_ff @(posedge clk) begin
      if (clr)      count <= '0;
      else if (inc) count <= count + 1'b1;
   end

endmodule

// File: rtl/fde_machine.sv
// Three-phase fetch/decode/execute sequencer with optional retire counter.
// Define FDE_INSTR_COUNT_EN to build the counter; otherwise instr_count is 0.
module fde_machine
   import fde_pkg::*;
#(
   parameter int COUNT_W = FDE_COUNT_W
) (
   input  logic clk,
   input  logic reset,
   fde_if.slave bus
);

   fde_phase_e state_q, state_d;

   // Phase register; reset overrides both enable and illegal-code recovery.
   always_ff @(posedge clk) begin
      if (reset) state_q <= FDE_FETCH;
      else       state_q <= state_d;
   end

   // Next phase: advance only when enabled, the unused code always falls back to FETCH.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FDE_FETCH:   if (bus.en) state_d = FDE_DECODE;
         FDE_DECODE:  if (bus.en) state_d = FDE_EXECUTE;
         FDE_EXECUTE: if (bus.en) state_d = FDE_FETCH;
         default:     state_d = FDE_FETCH;
      endcase
   end

   assign bus.state      = state_q;
   assign bus.fetch      = (state_q == FDE_FETCH);
   assign bus.decode     = (state_q == FDE_DECODE);
   assign bus.execute    = (state_q == FDE_EXECUTE);
   assign bus.instr_done = bus.execute & bus.en;

`ifdef FDE_INSTR_COUNT_EN
   // Retirement is exactly the EXECUTE->FETCH step, i.e. instr_done at an edge.
   fde_counter #(.COUNT_W(COUNT_W)) u_counter (
      .clk   (clk),
      .clr   (reset),
      .inc   (bus.instr_done),
      .count (bus.instr_count)
   );
`else
   assign bus.instr_count = '0;
`endif

endmodule

// File: tb/tb_fde_machine.sv
// Directed bench for fde_machine (counter checks follow FDE_INSTR_COUNT_EN).
module tb_fde_machine;
   import fde_pkg::*;

   localparam int CW = 2;
`ifdef FDE_INSTR_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   fde_if #(.COUNT_W(CW)) bus ();

   fde_machine #(.COUNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected count honouring the build option.
   function automatic logic [31:0] ec(input int v);
      return CNT_ON ? 32'(v) : 32'd0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_phase(input string tag, input logic [1:0] st);
      chk({tag, ".state"},   32'(bus.state),   32'(st));
      chk({tag, ".fetch"},   32'(bus.fetch),   32'(st == 2'b00));
      chk({tag, ".decode"},  32'(bus.decode),  32'(st == 2'b01));
      chk({tag, ".execute"}, 32'(bus.execute), 32'(st == 2'b10));
   endtask

   initial begin
      logic [1:0] seq [6];
      int         cnt_seq [5];
      seq     = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
      cnt_seq = '{1, 2, 3, 0, 1};

      // Reset
      reset  = 1'b1;
      bus.en = 1'b0;
      step();
      chk_phase("rst", 2'b00);
      chk("rst.cnt", 32'(bus.instr_count), 32'd0);

      // Hold with en=0 for 5 clocks
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_phase("hold", 2'b00);
         chk("hold.cnt", 32'(bus.instr_count), 32'd0);
      end

      // Run 6 clocks: D,E,F,D,E,F
      bus.en = 1'b1;
      #1;
      chk("run.done0", 32'(bus.instr_done), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk_phase("run", seq[i]);
         chk("run.done", 32'(bus.instr_done), 32'(seq[i] == 2'b10));
      end
      chk("run.cnt", 32'(bus.instr_count), ec(2));

      // Stall in DECODE
      step();
      chk_phase("stall.enter", 2'b01);
      bus.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_phase("stall", 2'b01);
         chk("stall.done", 32'(bus.instr_done), 32'd0);
      end
      bus.en = 1'b1;
      step();
      chk_phase("stall.exit", 2'b10);
      chk("stall.cnt", 32'(bus.instr_count), ec(2));

      // Reset during EXECUTE abandons the instruction
      reset = 1'b1;
      step();
      chk_phase("rst2", 2'b00);
      reset = 1'b0;
      step();
      step();
      chk_phase("mid.exec", 2'b10);
      chk("mid.done", 32'(bus.instr_done), 32'd1);
      reset = 1'b1;
      step();
      chk_phase("mid.rst", 2'b00);
      chk("mid.cnt", 32'(bus.instr_count), 32'd0);

      // Reset held with en=1 keeps reset outputs
      for (int i = 0; i < 3; i++) begin
         step();
         chk_phase("rsthold", 2'b00);
         chk("rsthold.cnt", 32'(bus.instr_count), 32'd0);
      end
      reset = 1'b0;

      // Five instructions, 2-bit counter wraps
      for (int k = 0; k < 5; k++) begin
         step();
         step();
         step();
         chk_phase("wrap", 2'b00);
         chk("wrap.cnt", 32'(bus.instr_count), ec(cnt_seq[k]));
      end

      // Illegal code recovers to FETCH with en=0
      bus.en = 1'b0;
      force dut.state_q = FDE_ILLEGAL;
      #1;
      chk("ill.state",   32'(bus.state),      32'd3);
      chk("ill.fetch",   32'(bus.fetch),      32'd0);
      chk("ill.decode",  32'(bus.decode),     32'd0);
      chk("ill.execute", 32'(bus.execute),    32'd0);
      chk("ill.done",    32'(bus.instr_done), 32'd0);
      release dut.state_q;
      step();
      chk_phase("ill.rec", 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fde_machine.md
FDE_MACHINE -- requirements
Module: fde_machine

Interface
REQ-001 Parameter COUNT_W, default 16: width of the retired-instruction counter.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 en  input  1  advance enable; 1 = step one phase per clock, 0 = hold.
REQ-005 fetch  output  1  high while in the FETCH phase.
REQ-006 decode  output  1  high while in the DECODE phase.
REQ-007 execute  output  1  high while in the EXECUTE phase.
REQ-008 state  output  2  current phase code: FETCH=2'b00, DECODE=2'b01, EXECUTE=2'b10.
REQ-009 instr_done  output  1  high when execute=1 and en=1, meaning the instruction retires on the next edge.
REQ-010 instr_count  output  COUNT_W  retired-instruction count.

Function
REQ-011 State SHALL be one 2-bit register; fetch/decode/execute SHALL be combinational decodes of that register.
REQ-012 With en=1, each rising edge SHALL advance FETCH->DECODE, DECODE->EXECUTE, then EXECUTE->FETCH.
REQ-013 With en=0, state and instr_count SHALL hold, and outputs SHALL stay unchanged.
REQ-014 In any legal state, exactly one of fetch/decode/execute SHALL be 1.
REQ-015 Illegal code 2'b11 SHALL drive fetch/decode/execute/instr_done all to 0.
REQ-016 From 2'b11, the next edge SHALL go to FETCH regardless of en.
REQ-017 instr_done SHALL be combinational: execute AND en.
REQ-018 instr_count SHALL increment by 1 on each EXECUTE->FETCH transition.
REQ-019 instr_count SHALL wrap from all-ones to 0 with no flag.
REQ-020 A phase transition SHALL take exactly one clock; there are no wait states other than en=0.
REQ-021 en SHALL be sampled only at the rising clock edge; glitches between edges have no effect.

Reset
REQ-022 When reset=1 at a rising edge: state=FETCH, fetch=1, decode=0, execute=0, instr_count=0.
REQ-023 Reset SHALL take priority over en and over illegal-state recovery.
REQ-024 Reset asserted mid-instruction (DECODE or EXECUTE) SHALL abandon it without incrementing instr_count.
REQ-025 With reset held high, the outputs SHALL stay at reset values on every edge.
REQ-026 FETCH SHALL be reached on the first edge after reset regardless of power-up state.

Configuration
REQ-027 With macro FDE_INSTR_COUNT_EN defined, the counter SHALL be built per REQ-018/019.
REQ-028 Without FDE_INSTR_COUNT_EN, the instr_count port SHALL remain, tied to constant 0, and no counter flops SHALL be built.
REQ-029 All other behaviour SHALL be identical with or without the macro.

Structure
REQ-030 Shared package fde_pkg SHALL hold:
- the phase enum/typedef (2 bits);
- constants FDE_FETCH, FDE_DECODE, FDE_EXECUTE;
- the default COUNT_W value.
REQ-031 Sub-module fde_counter (COUNT_W-bit, synchronous clear, increment enable, wrap) SHALL implement instr_count.
REQ-032 fde_counter SHALL be instantiated only under FDE_INSTR_COUNT_EN.
REQ-033 The phase FSM SHALL stay in the top module.

Verification
REQ-034 Reset, then hold en=0 for 5 clocks -> fetch=1, state=00, and instr_count=0 throughout.
REQ-035 Reset, then en=1 for 6 clocks -> phase sequence D,E,F,D,E,F; instr_count=2; instr_done=1 on the two EXECUTE cycles.
REQ-036 en=1, then drop en to 0 while in DECODE for 3 clocks -> decode stays 1; after en=1, the next edge gives EXECUTE.
REQ-037 Assert reset while in EXECUTE with en=1 -> next edge gives FETCH and instr_count unchanged at 0 (not incremented).
REQ-038 Macro on, COUNT_W=2, run 5 instructions -> instr_count sequence 1,2,3,0,1; macro off -> instr_count always 0.
REQ-039 Force state to 2'b11 with en=0 -> all phase outputs 0; next edge gives FETCH=1.
